comar_or_sequencer: RTL and testbench

Shares one first-order 2-share COMAR OR gadget (two-register-stage, 6-bit fresh-mask input) between `NUM_REQ` requesters. The block does three things:
- Round-robin arbitrates the requesters.
- Pulls one fresh 6-bit randomness word per operation from an upstream PRNG handshake, so no mask word is ever reused across operations.
- Aligns the word's slices to the gadget's two pipeline stages and tags each in-flight operation, so results return with the requester ID.

It sits between the masked datapath clients and the gadget instance, which is instantiated outside this block.

---
 rtl/comar_or_sequencer.sv | 110 +++++++++++
 tb/tb_comar_or_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comar_or_sequencer.sv
// comar_or_sequencer: round-robin sharing of one 2-share COMAR OR gadget, fresh mask word per operation, id-tagged results.
// Latency: issue in cycle t -> result in cycle t+2 (t+3 when COMAR_SEQ_RESULT_REG_EN is defined: registered results).
// Backpressure: issues only when a request and a fresh mask word are both valid; results cannot be stalled.
module comar_or_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2   // must equal $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_a,
  input  logic [2*NUM_REQ-1:0] req_b,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  input  logic [5:0]           rnd_data,
  output logic [1:0]           g_a,
  output logic [1:0]           g_b,
  output logic [5:0]           g_r,
  input  logic [1:0]           g_c,
  output logic                 res_valid,
  output logic [ID_W-1:0]      res_id,
  output logic [1:0]           res_c
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic            found;
  logic            issue;
  logic [ID_W:0]   scan_idx;
  logic [3:0]      r_hi;

  // Tag pipeline mirrors the gadget's two register stages.
  logic            s0_vld;
  logic [ID_W-1:0] s0_id;
  logic            s1_vld;
  logic [ID_W-1:0] s1_id;

  // Find the first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[scan_idx[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = scan_idx[ID_W-1:0];
      end
    end
  end

  // No issue without a fresh mask word, and nothing is consumed while reset is held,
  // so a mask word can never be swallowed by a cleared pipeline.
  assign issue     = found & rnd_valid & rst_n;
  assign req_ready = issue ? (NUM_REQ'(1) << grant_id) : '0;
  assign rnd_ready = issue;

  // Operands and stage-0 mask slice go straight to the gadget in the issue cycle.
  assign g_a = issue ? req_a[{grant_id, 1'b0} +: 2] : 2'b00;
  assign g_b = issue ? req_b[{grant_id, 1'b0} +: 2] : 2'b00;

  // Upper slice comes from the previous issue, so it lines up with the gadget's second stage.
  assign g_r = {r_hi, (issue ? rnd_data[1:0] : 2'b00)};

  // Advance the arbitration pointer, capture the stage-1 mask slice and shift the tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      r_hi   <= '0;
      s0_vld <= 1'b0;
      s0_id  <= '0;
      s1_vld <= 1'b0;
      s1_id  <= '0;
    end else begin
      if (issue) begin
        rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        r_hi   <= rnd_data[5:2];
      end
      s0_vld <= issue;
      s0_id  <= issue ? grant_id : '0;
      s1_vld <= s0_vld;
      s1_id  <= s0_id;
    end
  end

`ifdef COMAR_SEQ_RESULT_REG_EN
  // Register results so downstream logic never sees glitches from the gadget's XOR tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_c     <= 2'b00;
    end else begin
      res_valid <= s1_vld;
      res_id    <= s1_vld ? s1_id : '0;
      res_c     <= s1_vld ? g_c : 2'b00;
    end
  end
`else
  // Results are steered combinationally from the stage-1 tag; zeroed when nothing is in flight.
  assign res_valid = s1_vld;
  assign res_id    = s1_vld ? s1_id : '0;
  assign res_c     = s1_vld ? g_c : 2'b00;
`endif

endmodule

// File: tb/tb_comar_or_sequencer.sv
// tb_comar_or_sequencer: directed bench for comar_or_sequencer with a behavioural 2-stage masked OR gadget.
// Result latency expected: 2 cycles, 3 with COMAR_SEQ_RESULT_REG_EN.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_comar_or_sequencer;

`ifdef COMAR_SEQ_RESULT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rnd_valid;
  logic       rnd_ready;
  logic [5:0] rnd_data;
  logic [1:0] g_a;
  logic [1:0] g_b;
  logic [5:0] g_r;
  logic [1:0] g_c;
  logic       res_valid;
  logic [1:0] res_id;
  logic [1:0] res_c;

  int tests_run = 0;
  int fails     = 0;

  comar_or_sequencer #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_data  (rnd_data),
    .g_a       (g_a),
    .g_b       (g_b),
    .g_r       (g_r),
    .g_c       (g_c),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_c     (res_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gadget stand-in: unmasked OR travels two register stages; output shares are
  // re-masked with the stage-1 mask bit, so only the share XOR carries the value.
  logic gm_or0 = 1'b0;
  logic gm_or1 = 1'b0;
  logic gm_m1  = 1'b0;
  always @(posedge clk) begin
    gm_or0 <= (g_a[0] ^ g_a[1]) | (g_b[0] ^ g_b[1]);
    gm_or1 <= gm_or0;
    gm_m1  <= g_r[2];
  end
  assign g_c = {gm_or1 ^ gm_m1, gm_m1};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rnd_valid = 1'b0;
    rnd_data  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = 8'hFF;
    req_b     = 8'hFF;
    rnd_valid = 1'b1;
    rnd_data  = 6'h3F;
    @(posedge clk);
    @(negedge clk);
    tests_run++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    tests_run++; if (rnd_ready !== 1'b0) begin fails++; $display("FAIL reset_rnd_ready: got %b want 0", rnd_ready); end
    tests_run++; if (g_a !== 2'b00) begin fails++; $display("FAIL reset_g_a: got %b want 00", g_a); end
    tests_run++; if (g_b !== 2'b00) begin fails++; $display("FAIL reset_g_b: got %b want 00", g_b); end
    tests_run++; if (g_r !== 6'h00) begin fails++; $display("FAIL reset_g_r: got %h want 00", g_r); end
    tests_run++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    tests_run++; if (res_id !== 2'd0) begin fails++; $display("FAIL reset_res_id: got %0d want 0", res_id); end
    tests_run++; if (res_c !== 2'b00) begin fails++; $display("FAIL reset_res_c: got %b want 00", res_c); end
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    req_valid  = 4'b0010;
    req_a[3:2] = 2'b01;
    req_b[3:2] = 2'b00;
    rnd_valid  = 1'b1;
    rnd_data   = 6'h2D;
    @(negedge clk);
    tests_run++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL single_grant: got %b want 0010", req_ready); end
    tests_run++; if (rnd_ready !== 1'b1) begin fails++; $display("FAIL single_rnd_ready: got %b want 1", rnd_ready); end
    tests_run++; if (g_a !== 2'b01) begin fails++; $display("FAIL single_g_a: got %b want 01", g_a); end
    tests_run++; if (g_r[1:0] !== 2'b01) begin fails++; $display("FAIL single_g_r_lo: got %b want 01", g_r[1:0]); end
    next_cycle();
    clear_inputs();
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tests_run++; if (g_r !== 6'b101100) begin fails++; $display("FAIL single_g_r_stage1: got %b want 101100", g_r); end
      end
      tests_run++; if (res_valid !== (c == LAT)) begin fails++; $display("FAIL single_res_valid c%0d: got %b want %b", c, res_valid, (c == LAT)); end
      if (c == LAT) begin
        tests_run++; if (res_id !== 2'd1) begin fails++; $display("FAIL single_res_id: got %0d want 1", res_id); end
        tests_run++; if ((res_c[0] ^ res_c[1]) !== 1'b1) begin fails++; $display("FAIL single_res_or: got %b want 1", res_c[0] ^ res_c[1]); end
      end else begin
        tests_run++; if (res_c !== 2'b00) begin fails++; $display("FAIL single_res_c_idle c%0d: got %b want 00", c, res_c); end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic       rr_or [4];
    logic [3:0] exp_rdy;
    rr_or[0] = 1'b0; rr_or[1] = 1'b1; rr_or[2] = 1'b1; rr_or[3] = 1'b0;
    do_reset();
    req_a = 8'b11_10_01_00;
    req_b = 8'h00;
    for (int c = 0; c < LAT + 9; c++) begin
      if (c < 8) begin
        req_valid = 4'hF;
        rnd_valid = 1'b1;
        rnd_data  = 6'(c * 5 + 3);
      end else begin
        req_valid = 4'h0;
        rnd_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 8) begin
        exp_rdy = 4'b0001 << (c % 4);
        tests_run++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, exp_rdy); end
      end
      if (c >= LAT && c < LAT + 8) begin
        tests_run++; if (res_valid !== 1'b1) begin fails++; $display("FAIL rr_res_valid c%0d: got %b want 1", c, res_valid); end
        tests_run++; if (res_id !== 2'((c - LAT) % 4)) begin fails++; $display("FAIL rr_res_id c%0d: got %0d want %0d", c, res_id, (c - LAT) % 4); end
        tests_run++; if ((res_c[0] ^ res_c[1]) !== rr_or[(c - LAT) % 4]) begin fails++; $display("FAIL rr_res_or c%0d: got %b want %b", c, res_c[0] ^ res_c[1], rr_or[(c - LAT) % 4]); end
      end else begin
        tests_run++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rr_res_idle c%0d: got %b want 0", c, res_valid); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_starvation();
    do_reset();
    req_a[5:4] = 2'b10;
    req_b[5:4] = 2'b11;
    for (int c = 0; c < 5 + LAT + 2; c++) begin
      req_valid = (c <= 5) ? 4'b0100 : 4'b0000;
      rnd_valid = (c == 5);
      rnd_data  = 6'h1E;
      @(negedge clk);
      if (c < 5) begin
        tests_run++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL starve_req_ready c%0d: got %b want 0000", c, req_ready); end
        tests_run++; if (rnd_ready !== 1'b0) begin fails++; $display("FAIL starve_rnd_ready c%0d: got %b want 0", c, rnd_ready); end
      end else if (c == 5) begin
        tests_run++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL starve_grant: got %b want 0100", req_ready); end
      end
      tests_run++; if (res_valid !== (c == 5 + LAT)) begin fails++; $display("FAIL starve_res_valid c%0d: got %b want %b", c, res_valid, (c == 5 + LAT)); end
      if (c == 5 + LAT) begin
        tests_run++; if (res_id !== 2'd2) begin fails++; $display("FAIL starve_res_id: got %0d want 2", res_id); end
        tests_run++; if ((res_c[0] ^ res_c[1]) !== 1'b1) begin fails++; $display("FAIL starve_res_or: got %b want 1", res_c[0] ^ res_c[1]); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic       exp_or [16];
    logic [3:0] k;
    do_reset();
    for (int c = 0; c < 16 + LAT + 1; c++) begin
      if (c < 16) begin
        k          = 4'(c);
        req_valid  = 4'b0001;
        req_a[1:0] = k[3:2];
        req_b[1:0] = k[1:0];
        rnd_valid  = 1'b1;
        rnd_data   = (c == 0) ? 6'h3F : (c == 1) ? 6'h00 : 6'($urandom);
        exp_or[c]  = (k[3] ^ k[2]) | (k[1] ^ k[0]);
      end else begin
        clear_inputs();
      end
      @(negedge clk);
      if (c == 1) begin
        tests_run++; if (g_r !== 6'b111100) begin fails++; $display("FAIL b2b_g_r: got %b want 111100", g_r); end
      end
      if (c < 16) begin
        tests_run++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL b2b_grant c%0d: got %b want 0001", c, req_ready); end
      end
      if (c >= LAT && c < 16 + LAT) begin
        tests_run++; if (res_valid !== 1'b1) begin fails++; $display("FAIL b2b_res_valid c%0d: got %b want 1", c, res_valid); end
        tests_run++; if ((res_c[0] ^ res_c[1]) !== exp_or[c - LAT]) begin fails++; $display("FAIL b2b_res_or c%0d: got %b want %b", c, res_c[0] ^ res_c[1], exp_or[c - LAT]); end
      end else begin
        tests_run++; if (res_valid !== 1'b0) begin fails++; $display("FAIL b2b_res_idle c%0d: got %b want 0", c, res_valid); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 4'hF;
    req_a     = 8'h5A;
    req_b     = 8'h33;
    rnd_valid = 1'b1;
    rnd_data  = 6'h15;
    @(negedge clk);
    tests_run++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_grant_c0: got %b want 0001", req_ready); end
    next_cycle();
    @(negedge clk);
    tests_run++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL mid_grant_c1: got %b want 0010", req_ready); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_ready_in_reset: got %b want 0000", req_ready); end
    tests_run++; if (rnd_ready !== 1'b0) begin fails++; $display("FAIL mid_rnd_ready_in_reset: got %b want 0", rnd_ready); end
    next_cycle();
    rst_n = 1'b1;
    clear_inputs();
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      tests_run++; if (res_valid !== 1'b0) begin fails++; $display("FAIL mid_res_valid c%0d: got %b want 0", c, res_valid); end
      if (c == 2) begin
        tests_run++; if (g_r !== 6'h00) begin fails++; $display("FAIL mid_g_r_cleared: got %b want 000000", g_r); end
      end
      next_cycle();
    end
    req_valid = 4'hF;
    rnd_valid = 1'b1;
    @(negedge clk);
    tests_run++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_rr_restart: got %b want 0001", req_ready); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run %0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
